// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite ROM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sprite_pkg;

    // Colour that the pixel mux treats as "draw nothing"; also returned for out-of-range reads.
    localparam logic [5:0] TRANSP_KEY = 6'b110011;

    typedef logic [5:0] rgb6_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Cyclic first-one search: lowest set bit of req_i at or after start_i, wrapping around.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      start_i,
    output logic               found_o,
    output logic [IW-1:0]      idx_o
);

    // Walk the offsets from farthest to nearest so the nearest hit is the last one written.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int pos;
            pos = (int'(start_i) + k) % NUM_REQ;
            if (req_i[pos]) begin
                found_o = 1'b1;
                idx_o   = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one combinational sprite ROM between NUM_REQ pixel fetchers.
// Latency: grant is combinational; tagged read data is registered one cycle after the grant.
// Backpressure: requesters hold req until granted; bursts are capped at MAX_BURST grants.
// Optional macro SPRITE_ARB_TRANSP_EN adds the registered rd_transp output.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 14,
    parameter int ROM_DEPTH = 4140,
    parameter int MAX_BURST = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [5:0]                 rom_rgb,
    output logic                       rd_valid,
    output logic [$clog2(NUM_REQ)-1:0] rd_id,
    output logic [5:0]                 rd_rgb,
`ifdef SPRITE_ARB_TRANSP_EN
    output logic                       rd_transp,
`endif
    output logic                       rd_oob
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = 8;

    arb_state_t    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [IW-1:0] owner_nxt;
    logic [IW-1:0] search_start;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          keep_owner;
    logic          grant_vld;
    logic [IW-1:0] grant_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic          sel_oob;
    rgb6_t         rgb_d;

    logic          rd_valid_q;
    logic [IW-1:0] rd_id_q;
    rgb6_t         rd_rgb_q;
    logic          rd_oob_q;
`ifdef SPRITE_ARB_TRANSP_EN
    logic          rd_transp_q;
`endif

    assign owner_nxt  = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
    assign keep_owner = (state_q == BURST) && req[owner_q] && (cnt_q < CW'(MAX_BURST - 1));
    // Mid-burst rotation searches past the owner; the owner still wins if it is alone.
    assign search_start = (state_q == BURST) ? owner_nxt : rr_ptr_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_pick (
        .req_i   (req),
        .start_i (search_start),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Grant selection and next-state for owner, burst counter and rotation pointer.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        rr_ptr_d  = rr_ptr_q;
        grant_vld = 1'b0;
        grant_idx = owner_q;
        if (!rst) begin
            if (keep_owner) begin
                grant_vld = 1'b1;
                cnt_d     = cnt_q + CW'(1);
            end else begin
                if (state_q == BURST) begin
                    rr_ptr_d = owner_nxt;
                end
                if (pick_found) begin
                    grant_vld = 1'b1;
                    grant_idx = pick_idx;
                    owner_d   = pick_idx;
                    cnt_d     = '0;
                    state_d   = BURST;
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    // Route the granted address to the ROM; out-of-range addresses read entry 0 and are keyed.
    always_comb begin
        sel_addr = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
        sel_oob  = grant_vld && (32'(sel_addr) >= 32'(ROM_DEPTH));
        gnt      = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
        rom_addr = (grant_vld && !sel_oob) ? sel_addr : '0;
        rgb_d    = sel_oob ? TRANSP_KEY : rom_rgb;
    end

    // Arbiter state plus the read-return register; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_id_q     <= '0;
            rd_rgb_q    <= '0;
            rd_oob_q    <= 1'b0;
`ifdef SPRITE_ARB_TRANSP_EN
            rd_transp_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            rd_valid_q <= grant_vld;
            if (grant_vld) begin
                rd_id_q  <= grant_idx;
                rd_rgb_q <= rgb_d;
                rd_oob_q <= sel_oob;
            end
`ifdef SPRITE_ARB_TRANSP_EN
            rd_transp_q <= grant_vld && (rgb_d == TRANSP_KEY);
`endif
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_id    = rd_id_q;
    assign rd_rgb   = rd_rgb_q;
    assign rd_oob   = rd_oob_q;
`ifdef SPRITE_ARB_TRANSP_EN
    assign rd_transp = rd_transp_q;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a small behavioural ROM.
// Latency: checks combinational grant in-cycle and registered read data one cycle later.
// Backpressure: requests are held by the bench until the intended grant is observed.
module tb_sprite_rom_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 14;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_addr;
    logic [5:0]                rom_rgb;
    logic                      rd_valid;
    logic [1:0]                rd_id;
    logic [5:0]                rd_rgb;
    logic                      rd_oob;
`ifdef SPRITE_ARB_TRANSP_EN
    logic                      rd_transp;
`endif

    int n_vec;
    int n_err;

    sprite_rom_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ADDR_W    (ADDR_W),
        .ROM_DEPTH (4140),
        .MAX_BURST (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_rgb   (rom_rgb),
        .rd_valid  (rd_valid),
        .rd_id     (rd_id),
        .rd_rgb    (rd_rgb),
`ifdef SPRITE_ARB_TRANSP_EN
        .rd_transp (rd_transp),
`endif
        .rd_oob    (rd_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: entry 5 is 6'h3C, every other entry is addr[5:0] ^ 6'h15.
    function automatic logic [5:0] rom_fn(input logic [13:0] a);
        if (a == 14'd5) return 6'h3C;
        return a[5:0] ^ 6'h15;
    endfunction

    always_comb rom_rgb = rom_fn(rom_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [13:0] a);
        req_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        req      = '0;
        req_addr = '0;
        rst      = 1'b1;

        // Reset state; grant must stay low while rst even with all requesting.
        tick();
        req = 4'b1111;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        tick();
        check("rst_valid", 32'(rd_valid), 32'h0);
        check("rst_id", 32'(rd_id), 32'h0);
        check("rst_rgb", 32'(rd_rgb), 32'h0);
        check("rst_oob", 32'(rd_oob), 32'h0);
        req = '0;
        rst = 1'b0;
        #1;
        check("idle_gnt", 32'(gnt), 32'h0);
        check("idle_romaddr", 32'(rom_addr), 32'h0);

        // Single requester 2, addr 5.
        set_addr(2, 14'd5);
        req = 4'b0100;
        #1;
        check("t1_gnt", 32'(gnt), 32'h4);
        check("t1_romaddr", 32'(rom_addr), 32'd5);
        tick();
        check("t1_valid", 32'(rd_valid), 32'h1);
        check("t1_id", 32'(rd_id), 32'd2);
        check("t1_rgb", 32'(rd_rgb), 32'h3C);
        check("t1_oob", 32'(rd_oob), 32'h0);
        req = '0;
        #1;
        check("t1_gnt_off", 32'(gnt), 32'h0);
        tick();
        check("t1_valid_off", 32'(rd_valid), 32'h0);
        check("t1_rgb_hold", 32'(rd_rgb), 32'h3C);
        check("t1_id_hold", 32'(rd_id), 32'd2);

        // All four requesting: 8-grant bursts in order 0,1,2,3,0 with no gaps.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_addr(i, 14'(16 + i));
        req = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            int own;
            own = (c / 8) % 4;
            #1;
            check("t2_gnt", 32'(gnt), 32'(1 << own));
            tick();
            check("t2_valid", 32'(rd_valid), 32'h1);
            check("t2_id", 32'(rd_id), 32'(own));
            check("t2_rgb", 32'(rd_rgb), 32'(rom_fn(14'(16 + own))));
        end
        req = '0;

        // Lone requester 1 keeps the port through counter wrap.
        do_reset();
        set_addr(1, 14'd10);
        req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            #1;
            check("t3_gnt", 32'(gnt), 32'h2);
            tick();
            check("t3_valid", 32'(rd_valid), 32'h1);
            check("t3_rgb", 32'(rd_rgb), 32'h1F);
        end
        req = '0;

        // Address range boundary on requester 3: 4139 in range, 4140 out of range.
        do_reset();
        set_addr(3, 14'd4139);
        req = 4'b1000;
        #1;
        check("t4_gnt_in", 32'(gnt), 32'h8);
        check("t4_romaddr_in", 32'(rom_addr), 32'd4139);
        tick();
        check("t4_rgb_in", 32'(rd_rgb), 32'h3E);
        check("t4_oob_in", 32'(rd_oob), 32'h0);
        set_addr(3, 14'd4140);
        #1;
        check("t4_gnt_oob", 32'(gnt), 32'h8);
        check("t4_romaddr_oob", 32'(rom_addr), 32'h0);
        tick();
        check("t4_valid", 32'(rd_valid), 32'h1);
        check("t4_id", 32'(rd_id), 32'd3);
        check("t4_rgb_oob", 32'(rd_rgb), 32'h33);
        check("t4_oob", 32'(rd_oob), 32'h1);
`ifdef SPRITE_ARB_TRANSP_EN
        check("t4_transp", 32'(rd_transp), 32'h1);
`endif
        req = '0;

        // Reset mid-burst (owner 2 after four grants), then rotation restarts at 0.
        do_reset();
        set_addr(1, 14'd20);
        set_addr(2, 14'd7);
        req = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t5_gnt_pre", 32'(gnt), 32'h4);
            tick();
        end
        rst = 1'b1;
        #1;
        check("t5_gnt_rst", 32'(gnt), 32'h0);
        tick();
        check("t5_valid_rst", 32'(rd_valid), 32'h0);
        rst = 1'b0;
        req = 4'b0110;
        #1;
        check("t5_gnt_after", 32'(gnt), 32'h2);
        tick();
        check("t5_id_after", 32'(rd_id), 32'd1);
        check("t5_rgb_after", 32'(rd_rgb), 32'h01);
        req = '0;

        // Owner 0 drops its request; requester 3 is granted in the same cycle.
        do_reset();
        set_addr(0, 14'd8);
        set_addr(3, 14'd9);
        req = 4'b1001;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("t6_gnt_own", 32'(gnt), 32'h1);
            tick();
        end
        req = 4'b1000;
        #1;
        check("t6_gnt_swap", 32'(gnt), 32'h8);
        check("t6_romaddr", 32'(rom_addr), 32'd9);
        tick();
        check("t6_valid", 32'(rd_valid), 32'h1);
        check("t6_id", 32'(rd_id), 32'd3);
        check("t6_rgb", 32'(rd_rgb), 32'h1C);
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
